phase_readout: RTL and testbench
================================

Name: phase_readout

Overview:
- Read-side companion to the weight-write path of the Ising core.
- Samples the free-running oscillator outputs, measures each oscillator's phase offset against oscillator 0 over a fixed clk window, and returns the results through a valid/ready register-read handshake.
- Sits beside the core matrix on the same clk/axi_rstn domain. The host reads spin/phase results after annealing.

Parameters:
- N, 8, number of oscillators (N >= 2, N <= 64).
- WINDOW_LOG2, 10, window length is 2^WINDOW_LOG2 clk cycles.
- ADDR_BASE, 32'h0002_0000, read base address.
- ADDR_MASK, 32'hFFFF_0000, upper address bits compared against ADDR_BASE.

Ports:
- clk  input  1  system clock.
- axi_rstn  input  1  asynchronous active-low reset.
- ising_rstn  input  1  core run enable, synchronous to clk. Low clears measurement state.
- osc_in  input  N  oscillator outputs, asynchronous to clk.
- arvalid  input  1  read request valid.
- arready  output  1  block can accept a request.
- araddr  input  32  read address.
- rvalid  output  1  read data valid.
- rready  input  1  host accepts data.
- rdata  output  32  read data.

Behaviour:
- Reset (axi_rstn low, asynchronous):
  - arready=0, rvalid=0, rdata=0.
  - Synchronizers, counters, results, window counter and window_id all cleared.
  - arready rises on the first clk edge after reset release.
- Synchronizer: 2-flop per osc_in bit gives sync[N-1:0]. Measurement adds 2 cycles of input latency.
- Window counter: WINDOW_LOG2 bits, increments every cycle while ising_rstn=1.
- Accumulators: each cycle, acc[i] (WINDOW_LOG2+1 bits, i=1..N-1) increments when sync[i] != sync[0]. acc[0] is unused and reads as 0.
- Window end (window counter == all-ones):
  - result[i] <= acc[i] including that cycle's increment.
  - acc cleared, window_id (16 bits, wraps) increments.
  - result=0 means in phase. result=2^WINDOW_LOG2 means antiphase.
- ising_rstn=0: window counter and acc held at 0. result and window_id are retained. A new window starts on the first cycle ising_rstn=1.
- Read FSM:
  - IDLE: arready=1, rvalid=0. On arvalid&&arready, decode, register rdata, go to RESP.
  - RESP: arready=0, rvalid=1, rdata stable. On rready, go to IDLE. arready returns the following cycle.
  - Request-to-rvalid latency is 1 cycle. Minimum of 2 cycles per transaction.
- Decode:
  - A match requires (araddr & ADDR_MASK) == ADDR_BASE.
  - idx = araddr[15:2] (word addressed).
  - idx < N: rdata = zero-extended result[idx].
  - idx == N: rdata = {window_id, 15'b0, ising_rstn}.
  - Any other idx: rdata = 32'h0.
  - Address mismatch: rdata = 32'hFFFF_FFFF.
- A result update during RESP does not alter the held rdata. The next read returns the new value.
- The index-N status word lets the host confirm a fresh window.
- arvalid during RESP is not accepted. The host holds arvalid until arready.

Optional Feature:
- Macro: PHASE_READOUT_SNAPSHOT_EN.
- Defined: idx == N+1 returns the zero-extended instantaneous sync[N-1:0], captured at request acceptance (truncated to 32 bits if N > 32). The idx-N status word is unchanged.
- Undefined: idx == N+1 returns 32'h0 like any other out-of-range index. No snapshot logic is synthesized.

Test Plan:
- Reset: hold axi_rstn low 5 cycles -> arready=0, rvalid=0, rdata=0. arready=1 one cycle after release.
- In-phase (N=4, WINDOW_LOG2=4): all osc_in driven by the same square wave, run 2 windows, read idx 1..3 -> 0 each. idx 4 -> window_id>=1 and bit0=1.
- Antiphase: osc_in[2]=~osc_in[0], osc_in[1]=osc_in[0], osc_in[3] constant while osc_in[0] toggles every 4 cycles. After a full window, read idx 2 -> 16, idx 1 -> 0, idx 3 -> 8.
- Backpressure: issue read, hold rready=0 for 20 cycles across a window boundary -> rvalid stays 1, rdata unchanged, arready=0. Release rready, re-read -> updated value.
- Decode: araddr=32'h0003_0004 -> 32'hFFFF_FFFF. araddr=ADDR_BASE+4*10 -> 32'h0. With PHASE_READOUT_SNAPSHOT_EN and osc_in=4'b1010 held, idx 5 -> 32'h0000_000A.
- ising_rstn low mid-window: after a full anti-phase window, drop ising_rstn for 10 cycles then raise -> prior result held during the low period. The next result counts only the new full window. window_id increments exactly once per completed window.

Source files
------------

// File: rtl/phase_readout.sv
// phase_readout: measures each oscillator's phase offset against oscillator 0 over a
// 2^WINDOW_LOG2-cycle window and serves results through a valid/ready read port.
// Build option PHASE_READOUT_SNAPSHOT_EN adds a raw synchronized-input word at index N+1.

module phase_readout #(
    parameter int unsigned N           = 8,
    parameter int unsigned WINDOW_LOG2 = 10,
    parameter logic [31:0] ADDR_BASE   = 32'h0002_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFF_0000
) (
    input  logic         clk,
    input  logic         axi_rstn,
    input  logic         ising_rstn,
    input  logic [N-1:0] osc_in,
    input  logic         arvalid,
    output logic         arready,
    input  logic [31:0]  araddr,
    output logic         rvalid,
    input  logic         rready,
    output logic [31:0]  rdata
);

    localparam int unsigned ACC_W = WINDOW_LOG2 + 1;
    localparam int unsigned IDX_W = $clog2(N);
    localparam logic [13:0] IDX_STATUS = 14'(N);
    localparam logic [WINDOW_LOG2-1:0] CNT_ZERO = {WINDOW_LOG2{1'b0}};
    localparam logic [WINDOW_LOG2-1:0] CNT_ONE  = WINDOW_LOG2'(1);
    localparam logic [WINDOW_LOG2-1:0] CNT_LAST = {WINDOW_LOG2{1'b1}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    logic [N-1:0]             sync1_q;
    logic [N-1:0]             sync2_q;
    logic [WINDOW_LOG2-1:0]   win_cnt_q;
    logic [WINDOW_LOG2-1:0]   win_cnt_d;
    logic [ACC_W-1:0]         acc_q    [N];
    logic [ACC_W-1:0]         acc_d    [N];
    logic [ACC_W-1:0]         result_q [N];
    logic [ACC_W-1:0]         result_d [N];
    logic [15:0]              window_id_q;
    logic [15:0]              window_id_d;
    logic                     win_end_s;

    state_t                   state_q;
    state_t                   state_d;
    logic                     arready_q;
    logic                     arready_d;
    logic                     rvalid_q;
    logic                     rvalid_d;
    logic [31:0]              rdata_q;
    logic [31:0]              rdata_d;

    logic                     addr_hit_s;
    logic [13:0]              idx_s;
    logic [31:0]              dec_s;
    logic                     unused_s;

    assign unused_s = ^araddr[1:0];

    // Two-flop synchronizer for the free-running oscillator inputs
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            sync1_q <= {N{1'b0}};
            sync2_q <= {N{1'b0}};
        end else begin
            sync1_q <= osc_in;
            sync2_q <= sync1_q;
        end
    end

    assign win_end_s = ising_rstn && (win_cnt_q == CNT_LAST);

    // Window counter, mismatch accumulators and result capture
    always_comb begin
        win_cnt_d   = win_cnt_q;
        window_id_d = window_id_q;
        for (int i = 0; i < N; i++) begin
            acc_d[i]    = acc_q[i];
            result_d[i] = result_q[i];
        end
        if (!ising_rstn) begin
            win_cnt_d = CNT_ZERO;
            for (int i = 0; i < N; i++) begin
                acc_d[i] = ACC_ZERO;
            end
        end else begin
            win_cnt_d = win_cnt_q + CNT_ONE;
            for (int i = 1; i < N; i++) begin
                acc_d[i] = acc_q[i] + {{(ACC_W-1){1'b0}}, sync2_q[i] ^ sync2_q[0]};
            end
            // The closing cycle's increment is folded in before the result is latched.
            if (win_end_s) begin
                for (int i = 0; i < N; i++) begin
                    result_d[i] = acc_d[i];
                    acc_d[i]    = ACC_ZERO;
                end
                window_id_d = window_id_q + 16'd1;
            end else begin
                window_id_d = window_id_q;
            end
        end
        acc_d[0]    = ACC_ZERO;
        result_d[0] = ACC_ZERO;
    end

    // Measurement state registers
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            win_cnt_q   <= CNT_ZERO;
            window_id_q <= 16'd0;
            for (int i = 0; i < N; i++) begin
                acc_q[i]    <= ACC_ZERO;
                result_q[i] <= ACC_ZERO;
            end
        end else begin
            win_cnt_q   <= win_cnt_d;
            window_id_q <= window_id_d;
            for (int i = 0; i < N; i++) begin
                acc_q[i]    <= acc_d[i];
                result_q[i] <= result_d[i];
            end
        end
    end

`ifdef PHASE_READOUT_SNAPSHOT_EN
    localparam logic [13:0] IDX_SNAP = 14'(N + 1);
    logic [31:0] snap_s;

    if (N >= 32) begin : g_snap_trunc
        assign snap_s = sync2_q[31:0];
    end else begin : g_snap_ext
        assign snap_s = {{(32-N){1'b0}}, sync2_q};
    end
`endif

    // Address decode of the read word presented with the request
    always_comb begin
        addr_hit_s = ((araddr & ADDR_MASK) == ADDR_BASE);
        idx_s      = araddr[15:2];
        dec_s      = 32'h0000_0000;
        if (!addr_hit_s) begin
            dec_s = 32'hFFFF_FFFF;
        end else if (idx_s < IDX_STATUS) begin
            dec_s = 32'(result_q[idx_s[IDX_W-1:0]]);
        end else if (idx_s == IDX_STATUS) begin
            dec_s = {window_id_q, 15'b0, ising_rstn};
`ifdef PHASE_READOUT_SNAPSHOT_EN
        end else if (idx_s == IDX_SNAP) begin
            dec_s = snap_s;
`endif
        end else begin
            dec_s = 32'h0000_0000;
        end
    end

    // Read FSM state and registered handshake outputs
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q   <= ST_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // Read FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arvalid && arready_q) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (rready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read FSM outputs, computed one cycle ahead so they leave the block registered
    always_comb begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        case (state_d)
            ST_IDLE: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
            end
            ST_RESP: begin
                arready_d = 1'b0;
                rvalid_d  = 1'b1;
            end
            default: begin
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
            end
        endcase
        if ((state_q == ST_IDLE) && (state_d == ST_RESP)) begin
            rdata_d = dec_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_phase_readout.sv
// Directed bench for phase_readout with N=4, WINDOW_LOG2=4 (16-cycle windows).
// Table of decode vectors plus hand-written reset, window and backpressure sequences.

module tb_phase_readout;

    localparam int N  = 4;
    localparam int WL = 4;
    localparam logic [31:0] BASE = 32'h0002_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic         clk = 1'b0;
    logic         axi_rstn = 1'b0;
    logic         ising_rstn = 1'b0;
    logic [N-1:0] osc_in;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  araddr = 32'h0;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [31:0]  rdata;

    int           n_checks = 0;
    int           n_pass = 0;
    int           osc_mode = 0;
    logic [N-1:0] osc_static = '0;
    logic [7:0]   ph = 8'd0;

    phase_readout #(
        .N(N),
        .WINDOW_LOG2(WL),
        .ADDR_BASE(BASE),
        .ADDR_MASK(32'hFFFF_0000)
    ) dut (
        .clk(clk),
        .axi_rstn(axi_rstn),
        .ising_rstn(ising_rstn),
        .osc_in(osc_in),
        .arvalid(arvalid),
        .arready(arready),
        .araddr(araddr),
        .rvalid(rvalid),
        .rready(rready),
        .rdata(rdata)
    );

    initial forever #5 clk = ~clk;

    // Oscillator stimulus: square wave toggling every 4 cycles, several relationships
    initial begin
        osc_in = '0;
        forever begin
            @(negedge clk);
            ph = ph + 8'd1;
            case (osc_mode)
                0: osc_in = {N{ph[2]}};
                1: osc_in = {1'b0, ~ph[2], ph[2], ph[2]};
                default: osc_in = osc_static;
            endcase
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic do_read(input string nm, input logic [31:0] addr, output logic [31:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (arready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (arready !== 1'b1) begin
            check({nm, "_arready_timeout"}, {31'b0, arready}, 32'd1);
            data = 32'hDEAD_BEEF;
            return;
        end
        arvalid = 1'b1;
        araddr  = addr;
        rready  = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check({nm, "_lat"}, {30'b0, rvalid, arready}, 32'd2);
        data = rdata;
        @(negedge clk);
        rready = 1'b0;
    endtask

    vec_t        vecs[9];
    logic [31:0] d;
    logic [31:0] held;
    logic [15:0] wid_a;
    int          bp_bad;

    initial begin
        vecs[0] = '{BASE + 32'd0,          32'd0,         "idx0"};
        vecs[1] = '{BASE + 32'd4,          32'd0,         "idx1_inphase"};
        vecs[2] = '{BASE + 32'd8,          32'd16,        "idx2_antiphase"};
        vecs[3] = '{BASE + 32'd12,         32'd8,         "idx3_quarter"};
        vecs[4] = '{BASE + 32'd9,          32'd16,        "idx2_lowbits"};
        vecs[5] = '{BASE + 32'd40,         32'd0,         "idx10_oor"};
        vecs[6] = '{32'h0003_0004,         32'hFFFF_FFFF, "miss_0003"};
        vecs[7] = '{32'h0012_0008,         32'hFFFF_FFFF, "miss_0012"};
        vecs[8] = '{BASE + 32'h0000_FFFC,  32'd0,         "idx_max"};

        // Reset behaviour
        repeat (5) @(negedge clk);
        check("rst_arready", {31'b0, arready}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        axi_rstn = 1'b1;
        #1;
        check("rel_arready_before_edge", {31'b0, arready}, 32'd0);
        @(negedge clk);
        check("rel_arready_after_edge", {31'b0, arready}, 32'd1);

        // In-phase: two windows with all oscillators identical
        osc_mode   = 0;
        ising_rstn = 1'b1;
        repeat (40) @(negedge clk);
        for (int k = 1; k < N; k++) begin
            do_read($sformatf("inphase_idx%0d", k), BASE + 32'(4 * k), d);
            check($sformatf("inphase_idx%0d", k), d, 32'd0);
        end
        do_read("inphase_status", BASE + 32'd16, d);
        check("inphase_status_run", {31'b0, d[0]}, 32'd1);
        check("inphase_wid_ge1", {31'b0, (d[31:16] >= 16'd1)}, 32'd1);

        // Antiphase: exactly one window of 16 enabled cycles
        ising_rstn = 1'b0;
        osc_mode   = 1;
        repeat (5) @(negedge clk);
        do_read("status_before", BASE + 32'd16, d);
        check("status_before_low", {16'd0, d[15:0]}, 32'd0);
        wid_a = d[31:16];
        ising_rstn = 1'b1;
        repeat (16) @(negedge clk);
        ising_rstn = 1'b0;
        for (int k = 0; k < 9; k++) begin
            do_read(vecs[k].name, vecs[k].addr, d);
            check(vecs[k].name, d, vecs[k].exp);
        end
        do_read("status_one_window", BASE + 32'd16, d);
        check("status_one_window", d, {wid_a + 16'd1, 15'b0, 1'b0});

        // Partial window aborted by ising_rstn low: results held, no window counted
        ising_rstn = 1'b1;
        repeat (7) @(negedge clk);
        ising_rstn = 1'b0;
        repeat (2) @(negedge clk);
        do_read("hold_idx2", BASE + 32'd8, d);
        check("hold_idx2", d, 32'd16);
        do_read("hold_status", BASE + 32'd16, d);
        check("hold_status", d, {wid_a + 16'd1, 15'b0, 1'b0});
        repeat (2) @(negedge clk);
        ising_rstn = 1'b1;
        repeat (16) @(negedge clk);
        ising_rstn = 1'b0;
        do_read("fresh_idx2", BASE + 32'd8, d);
        check("fresh_idx2", d, 32'd16);
        do_read("fresh_idx3", BASE + 32'd12, d);
        check("fresh_idx3", d, 32'd8);
        do_read("fresh_status", BASE + 32'd16, d);
        check("fresh_status", d, {wid_a + 16'd2, 15'b0, 1'b0});

        // Backpressure across a window boundary
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = BASE + 32'd16;
        rready  = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        check("bp_accept", {30'b0, rvalid, arready}, 32'd2);
        held = rdata;
        check("bp_first_data", held, {wid_a + 16'd2, 15'b0, 1'b0});
        bp_bad = 0;
        ising_rstn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 15) ising_rstn = 1'b0;
            if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== held) bp_bad++;
        end
        check("bp_stable_cycles_bad", 32'(bp_bad), 32'd0);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("bp_release", {30'b0, rvalid, arready}, 32'd1);
        do_read("bp_reread", BASE + 32'd16, d);
        check("bp_reread", d, {wid_a + 16'd3, 15'b0, 1'b0});

        // Snapshot word at index N+1
        osc_mode   = 2;
        osc_static = 4'b1010;
        repeat (4) @(negedge clk);
        do_read("idx5", BASE + 32'd20, d);
`ifdef PHASE_READOUT_SNAPSHOT_EN
        check("idx5_snapshot", d, 32'h0000_000A);
`else
        check("idx5_oor", d, 32'h0000_0000);
`endif
        do_read("status_final", BASE + 32'd16, d);
        check("status_final", d, {wid_a + 16'd3, 15'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
